// File: rtl/xt_lbus_master.sv
// xt_lbus_master: XT local bus initiator turning valid/ready requests into fixed-latency bus accesses.
// Optional XT_LBUS_ALIGN_CHK_EN rejects reserved/misaligned requests with an error response and no strobe.
package xt_lbus_pkg;
  localparam int LB_ADDR_WIDTH = 8;
  typedef struct packed {
    logic                     ren;
    logic                     wen;
    logic [LB_ADDR_WIDTH-1:0] addr;
    logic [1:0]               write_width;
    logic [31:0]              wdata;
  } lb_slave_t;
endpackage

module xt_lbus_master
  import xt_lbus_pkg::*;
#(
  parameter int RD_LATENCY = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic                     req_write,
  input  logic [LB_ADDR_WIDTH-1:0] req_addr,
  input  logic [1:0]               req_width,
  input  logic [31:0]              req_wdata,
  output logic                     resp_valid,
  input  logic                     resp_ready,
  output logic [31:0]              resp_rdata,
  output logic                     resp_err,
  output lb_slave_t                lb_out,
  input  logic [31:0]              lb_rdata
);
  if (RD_LATENCY < 0 || RD_LATENCY > 7) begin : g_bad_lat
    $error("RD_LATENCY must be in 0..7");
  end
  typedef enum logic [1:0] {IDLE, STROBE, WAIT, RESP} state_t;
  state_t    state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  lb_slave_t   lb_q, lb_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;
  logic        fault;
`ifdef XT_LBUS_ALIGN_CHK_EN
  assign fault = (req_width == 2'b11) || (req_width == 2'b01 && req_addr[0]) ||
                 (req_width == 2'b10 && req_addr[1:0] != 2'b00);
`else
  assign fault = 1'b0;
`endif
  assign req_ready  = state_q == IDLE;
  assign resp_valid = state_q == RESP;
  assign resp_rdata = rdata_q;
  assign resp_err   = err_q;
  assign lb_out     = lb_q;
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    lb_d    = lb_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    case (state_q)
      IDLE: if (req_valid) begin
        lb_d = '{ren: !req_write && !fault, wen: req_write && !fault, addr: req_addr,
                 write_width: req_width, wdata: req_write ? req_wdata : 32'd0};
        rdata_d = '0;
        err_d   = fault;
        state_d = fault ? RESP : STROBE;
      end
      STROBE: begin
        lb_d.ren = 1'b0;
        lb_d.wen = 1'b0;
        if (lb_q.wen) state_d = RESP;
        else if (RD_LATENCY == 0) begin
          rdata_d = lb_rdata;
          state_d = RESP;
        end else begin
          cnt_d   = 3'(RD_LATENCY - 1);
          state_d = WAIT;
        end
      end
      WAIT: begin
        cnt_d = cnt_q - 3'd1;
        if (cnt_q == 3'd0) begin
          rdata_d = lb_rdata;
          state_d = RESP;
        end
      end
      RESP: state_d = resp_ready ? IDLE : RESP;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      lb_q    <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      lb_q    <= lb_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end
endmodule

// File: doc/xt_lbus_master.md
Name: xt_lbus_master

Overview:
- Initiator end of the XT local bus. Turns single requests from a core-side valid/ready port into XT_LBUS accesses, driven as one `lb_slave_t` struct broadcast to all slaves.
- Reads use a fixed-latency OR-combined `lb_rdata` return, since slaves return no acknowledge. The block then delivers a response on a valid/ready response port.
- Sits between the CPU data-port decode and the peripheral cluster: UART, GPIO, timers and small RAMs.
- One outstanding transaction at a time.

Parameters:
- `RD_LATENCY`, default 1: cycles from the `ren` strobe cycle to the cycle in which `lb_rdata` is valid. Legal range 0..7; out of range is an elaboration error.

Ports:
- `clk`  input  1  system clock
- `rst`  input  1  synchronous, active-high reset
- `req_valid`  input  1  request present
- `req_ready`  output  1  request accepted when `req_valid && req_ready`
- `req_write`  input  1  1 = write, 0 = read
- `req_addr`  input  `LB_ADDR_WIDTH` (8)  byte address on the local bus
- `req_width`  input  2  00 byte, 01 half, 10 word, 11 reserved
- `req_wdata`  input  32  write data
- `resp_valid`  output  1  response present
- `resp_ready`  input  1  response consumed when `resp_valid && resp_ready`
- `resp_rdata`  output  32  read data; 0 for writes
- `resp_err`  output  1  error response
- `lb_out`  output  `lb_slave_t`  bus to slaves: `ren`, `wen`, `addr`, `write_width`, `wdata`
- `lb_rdata`  input  32  OR-combined slave read data

Behaviour:
- Reset: one clock, `clk`; `rst` is synchronous and active-high.
  - Every output register is cleared: `lb_out` = 0, `resp_valid` = 0, `resp_rdata` = 0, `resp_err` = 0, FSM = IDLE.
  - `req_ready` is a decode of the state, so it is 1 the cycle after reset.
- All `lb_out` fields are registered. `ren` and `wen` are never high together. Each strobe is high for exactly one cycle per transaction.
- `lb_out.addr`, `lb_out.write_width` and `lb_out.wdata` are loaded at accept and held until the next accept.
  - For reads, `wdata` is loaded as 0.
- FSM states: IDLE, STROBE, WAIT, RESP.
- IDLE: `req_ready` = 1. On accept at edge T:
  - latch the request;
  - load `lb_out` with `wen` = `req_write` and `ren` = !`req_write`;
  - go to STROBE.
- STROBE (cycle T+1):
  - strobe high on the bus.
  - Write: go to RESP with `resp_rdata` = 0 and `resp_err` = 0. `resp_valid` rises at T+2.
  - Read, `RD_LATENCY` = 0: capture `lb_rdata` at the end of T+1, go to RESP.
  - Read, `RD_LATENCY` > 0: load the 3-bit counter with `RD_LATENCY`-1, go to WAIT.
- At the edge leaving STROBE, the strobe is cleared.
- WAIT: decrement the counter. When the counter is 0, capture `lb_rdata` into `resp_rdata` and go to RESP.
  - Capture happens at the end of cycle T+1+`RD_LATENCY`.
  - `resp_valid` rises at T+2+`RD_LATENCY`.
- RESP:
  - `resp_valid` = 1; `resp_rdata` and `resp_err` are stable.
  - `req_ready` = 0.
  - On `resp_ready`, `resp_valid` drops at the next edge and the FSM goes to IDLE.
  - Next accept is possible one cycle later, so minimum write-to-write spacing is 3 cycles.
- `req_*` inputs are ignored outside IDLE. `resp_ready` is ignored outside RESP.
- Reset mid-transaction:
  - the transaction is dropped, with no response;
  - the strobe is cleared at that same edge;
  - no partial write is repeated.
- `req_width` = 11 is passed through unchanged (see Optional Feature).

Optional Feature:
- Macro: `XT_LBUS_ALIGN_CHK_EN`.
- Defined: a request is faulty if `req_width` = 11, or half with `addr[0]` = 1, or word with `addr[1:0]` ≠ 0.
  - A faulty request issues no strobe: `lb_out.ren` and `lb_out.wen` stay 0.
  - The FSM goes IDLE→RESP directly, with `resp_valid` at T+1, `resp_err` = 1 and `resp_rdata` = 0.
- Not defined: no check is made. `resp_err` is tied 0, and every accepted request is strobed as specified.

Test Plan:
- Reset: hold `rst` 2 cycles mid-read → `lb_out` = 0, `resp_valid` = 0, `req_ready` = 1 the cycle after `rst` falls, no late response.
- Word write, addr 0x10, data 0xDEADBEEF, `resp_ready` = 1 → `wen` = 1 only at T+1 with addr 0x10, `write_width` 10, wdata 0xDEADBEEF; `resp_valid` at T+2 with rdata 0, err 0; `req_ready` again at T+3.
- Read, addr 0x24, `RD_LATENCY` = 1, slave drives 0x12345678 only at T+2 → `ren` pulse at T+1, `resp_rdata` = 0x12345678 valid at T+3.
- `RD_LATENCY` = 0 and 3 builds → `resp_valid` at T+2 and T+5 respectively; data driven one cycle early or late is not captured.
- Backpressure: `resp_ready` = 0 for 5 cycles while new `req_valid` is asserted → `resp_valid`/`rdata` stable, `req_ready` = 0, no extra strobes; after release, the queued request is accepted one cycle later.
- With `XT_LBUS_ALIGN_CHK_EN`: word read at addr 0x02 → no `ren`, `resp_valid` at T+1, err = 1. Without the macro: same request → `ren` at T+1, err = 0.
